// File: rtl/spi_ram_burst.sv
// spi_ram_burst
// Command-driven single-port memory behind an SPI slave receive path.
// Each command is a 2-bit opcode plus a DATA_W payload.
// Write and read addresses auto-increment and wrap modulo MEM_DEPTH.
// Reads run as bursts of payload+1 words, presented on a tx_valid/tx_ready
// output handshake that accepts backpressure.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : asynchronous active-high reset
//   din       : {opcode[1:0], payload[DATA_W-1:0]}
//   rx_valid  : one-cycle pulse per command (no ready back)
//   dout      : read word, stable while tx_valid is high
//   tx_valid  : dout holds a word awaiting acceptance
//   tx_ready  : consumer accepts dout on tx_valid && tx_ready at a rising edge
//   busy      : FSM is not in IDLE
//   err       : one-cycle pulse after a rejected command
//
// Opcodes: 00 SET_WR, 01 WRITE, 10 SET_RD, 11 READ (burst of payload+1 words).
//
// Output handshake: a word transfers on every rising edge where tx_valid and
// tx_ready are both high. tx_valid, once raised, stays high and dout stays
// constant until that transfer.

module spi_ram_burst #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SET_WR = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RD = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    // Last valid address. Addresses wrap here, not at 2**ADDR_W.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    // Depth held one bit wider so MEM_DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W + 1)'(MEM_DEPTH);

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] cnt;

    logic [1:0]        opcode;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] addr_field;
    logic              addr_ok;

    // Control strobes produced by the output process.
    logic cmd_take;
    logic handshake;
    logic load_dout;
    logic err_next;

    assign opcode     = din[DATA_W+1:DATA_W];
    assign payload    = din[DATA_W-1:0];
    assign addr_field = payload[ADDR_W-1:0];
    assign addr_ok    = ({1'b0, addr_field} < DEPTH);

    function automatic logic [ADDR_W-1:0] inc_wrap(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rx_valid && opcode == OP_READ) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (tx_ready) begin
                    state_next = (cnt == '0) ? IDLE : FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output and strobe logic
    always_comb begin
        busy      = (state != IDLE);
        tx_valid  = (state == HOLD);
        cmd_take  = (state == IDLE) && rx_valid;
        handshake = (state == HOLD) && tx_ready;
        load_dout = (state == FETCH);
        // A command arriving mid-burst is dropped and flagged. An out-of-range
        // address command is flagged and leaves its address untouched.
        err_next  = (rx_valid && state != IDLE)
                  || (cmd_take && (opcode == OP_SET_WR || opcode == OP_SET_RD) && !addr_ok);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
            rd_addr <= '0;
            cnt     <= '0;
            dout    <= '0;
            err     <= 1'b0;
        end else begin
            err <= err_next;
            if (cmd_take) begin
                case (opcode)
                    OP_SET_WR: if (addr_ok) wr_addr <= addr_field;
                    OP_WRITE:  wr_addr <= inc_wrap(wr_addr);
                    OP_SET_RD: if (addr_ok) rd_addr <= addr_field;
                    OP_READ:   cnt <= payload;
                    default:   ;
                endcase
            end
            if (load_dout) begin
                dout <= mem[rd_addr];
            end
            if (handshake) begin
                rd_addr <= inc_wrap(rd_addr);
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    // Memory array. It is left out of reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (cmd_take && opcode == OP_WRITE) begin
            mem[wr_addr] <= payload;
        end
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst (DATA_W=8, ADDR_W=8, MEM_DEPTH=200).
// The driver issues commands and updates a plain array model of the memory.
// Expected read words go into exp_q. A monitor process compares err, busy and
// every accepted word against that model.

module tb_spi_ram_burst;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 200;

    logic          clk;
    logic          rst;
    logic [DW+1:0] din;
    logic          rx_valid;
    logic [DW-1:0] dout;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          err;

    spi_ram_burst #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .err      (err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference model state
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m [DEPTH];
    int            m_wr = 0;
    int            m_rd = 0;
    bit            err_now_exp = 0;  // err expected after the coming edge
    bit            err_due     = 0;  // err expected right now
    bit            new_read    = 0;  // READ accepted at the coming edge
    int            ready_mode  = 0;  // 0 high, 1 random, 2 low

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for one command, applied when it is issued.
    task automatic model_cmd(input logic [1:0] op, input logic [DW-1:0] pl);
        if (exp_q.size() != 0) begin
            err_now_exp = 1'b1;
        end else begin
            case (op)
                2'b00: if (int'(pl) < DEPTH) m_wr = int'(pl); else err_now_exp = 1'b1;
                2'b01: begin
                    m[m_wr] = pl;
                    m_wr = (m_wr + 1) % DEPTH;
                end
                2'b10: if (int'(pl) < DEPTH) m_rd = int'(pl); else err_now_exp = 1'b1;
                default: begin
                    for (int i = 0; i <= int'(pl); i++) begin
                        exp_q.push_back(m[m_rd]);
                        m_rd = (m_rd + 1) % DEPTH;
                    end
                    new_read = 1'b1;
                end
            endcase
        end
    endtask

    // Driver: one call per clock, all inputs driven at the falling edge.
    task automatic step(input bit v, input logic [1:0] op, input logic [DW-1:0] pl);
        @(negedge clk);
        rx_valid    = v;
        din         = {op, pl};
        err_now_exp = 1'b0;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
        if (v) model_cmd(op, pl);
    endtask

    task automatic idle();
        step(1'b0, 2'b00, '0);
    endtask

    task automatic wait_idle();
        ready_mode = 0;
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) idle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wait_idle_timeout actual=%0d words_left expected=0", exp_q.size());
            exp_q.delete();
        end
        idle();
        idle();
    endtask

    // Monitor: samples 1 ns after the falling edge. Outputs reflect the previous
    // rising edge; tx_ready is already driven for the next one.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            check("err", err, err_due);
            check("busy", busy, (exp_q.size() != 0) && !new_read);
            check("tx_valid_spurious", tx_valid && exp_q.size() == 0, 0);
            if (tx_valid && tx_ready && exp_q.size() != 0) begin
                check("dout", dout, exp_q.pop_front());
            end
        end
        err_due  = err_now_exp;
        new_read = 1'b0;
    end

    logic [DW-1:0] tv_dout [3] = '{8'hA1, 8'hB2, 8'hC3};
    bit            tv_pat  [7] = '{0, 1, 0, 1, 0, 1, 0};
    bit            busy_pat[7] = '{1, 1, 1, 1, 1, 1, 0};

    initial begin
        rst = 1'b1; rx_valid = 1'b0; din = '0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_dout", dout, 0);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fill the whole memory; wr_addr wraps back to 0.
        step(1, 2'b00, 8'd0);
        for (int i = 0; i < DEPTH; i++) step(1, 2'b01, 8'($urandom_range(0, 255)));

        // Write three words at 0x10, then burst them back with tx_ready high.
        step(1, 2'b00, 8'h10);
        step(1, 2'b01, 8'hA1);
        step(1, 2'b01, 8'hB2);
        step(1, 2'b01, 8'hC3);
        step(1, 2'b10, 8'h10);
        step(1, 2'b11, 8'd2);
        begin
            int w = 0;
            for (int j = 0; j < 7; j++) begin
                idle();
                #2;
                check("burst_tx_valid", tx_valid, tv_pat[j]);
                check("burst_busy", busy, busy_pat[j]);
                if (tv_pat[j]) begin
                    check("burst_dout", dout, tv_dout[w]);
                    w++;
                end
            end
        end
        // rd_addr and wr_addr both sit at 0x13 now.
        step(1, 2'b11, 8'd0);
        wait_idle();
        step(1, 2'b01, 8'h5A);
        step(1, 2'b10, 8'h13);
        step(1, 2'b11, 8'd0);
        wait_idle();

        // Backpressure: hold the second word for several cycles.
        step(1, 2'b10, 8'h10);
        ready_mode = 2;
        step(1, 2'b11, 8'd2);
        for (int i = 0; i < 20 && !tx_valid; i++) begin
            idle();
            #2;
        end
        ready_mode = 0;
        idle();            // accepts 0xA1
        ready_mode = 2;
        idle();            // FETCH of the second word
        for (int i = 0; i < 5; i++) begin
            idle();
            #2;
            check("stall_tx_valid", tx_valid, 1);
            check("stall_dout", dout, 8'hB2);
        end
        wait_idle();

        // Wrap at MEM_DEPTH and out-of-range addresses.
        step(1, 2'b00, 8'd199);
        step(1, 2'b01, 8'h11);
        step(1, 2'b01, 8'h22);
        step(1, 2'b10, 8'd199);
        step(1, 2'b10, 8'd250);
        step(1, 2'b10, 8'd200);
        step(1, 2'b00, 8'd255);
        step(1, 2'b11, 8'd1);
        wait_idle();
        step(1, 2'b01, 8'h33);     // wr_addr should still be 1
        step(1, 2'b10, 8'd0);
        step(1, 2'b11, 8'd2);
        wait_idle();

        // Commands during a burst are rejected.
        ready_mode = 1;
        step(1, 2'b10, 8'd5);
        ready_mode = 1;
        step(1, 2'b11, 8'd3);
        step(1, 2'b01, 8'h55);
        step(1, 2'b00, 8'd7);
        idle();
        step(1, 2'b11, 8'd0);
        wait_idle();
        step(1, 2'b10, 8'(m_wr));
        step(1, 2'b11, 8'd1);
        wait_idle();

        // Longest burst: 2**DATA_W words, wrapping through the whole memory.
        step(1, 2'b10, 8'd150);
        step(1, 2'b11, 8'd255);
        wait_idle();

        // Reset in HOLD mid-burst.
        step(1, 2'b10, 8'h10);
        ready_mode = 2;
        step(1, 2'b11, 8'd4);
        idle();
        idle();
        idle();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        err_now_exp = 1'b0;
        m_wr = 0;
        m_rd = 0;
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_dout", dout, 0);
        @(negedge clk);
        rst = 1'b0;
        ready_mode = 0;
        step(1, 2'b10, 8'h10);
        step(1, 2'b11, 8'd2);
        wait_idle();
        step(1, 2'b11, 8'd1);      // rd_addr reset to 0 before the SET_RD above
        wait_idle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic [1:0]    op;
            logic [DW-1:0] pl;
            ready_mode = $urandom_range(0, 1);
            op = 2'($urandom_range(0, 3));
            pl = (op == 2'b11) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            step($urandom_range(0, 2) != 0, op, pl);
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
